// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t         : fetch FSM states
//   NOP_INSTR             : word delivered in place of a timed-out fetch (addi x0,x0,0)
//   FETCH_TIMEOUT_DEFAULT : default number of cycles a read may stay unacknowledged
package risco5_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR             = 32'h0000_0013;
  localparam int unsigned FETCH_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-read and decode-handshake bundle of the fetch stage.
//   mem_req/mem_addr      : read request and word address (fetch -> memory)
//   mem_ack/mem_rdata     : read completion and returned word (memory -> fetch)
//   instr_valid/instr_data/instr_pc/instr_fault : buffered instruction (fetch -> decode)
//   instr_ready           : decode accepts (decode -> fetch)
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_fault;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output instr_valid, instr_data, instr_pc, instr_fault,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  instr_valid, instr_data, instr_pc, instr_fault,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage sitting directly after the PC register.
// Samples the PC, issues one word read, buffers the returned word for decode
// behind a valid/ready handshake and pulses pc_inc once per delivered word.
// Redirects (flush) discard in-flight data; an unanswered read times out into
// a NOP flagged with instr_fault.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   pc_i   : current PC register value
//   pc_inc : one-cycle pulse, PC advances by one word at the next edge
//   flush  : redirect, asserted in the cycle the PC is loaded
//   bus    : memory request/response and decode handshake (master side)
module fetch_unit
  import risco5_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = FETCH_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  pc_inc,
  input  logic                  flush,
  fetch_unit_if.master          bus
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  fetch_state_t     state;
  logic             drop;
  logic             first_valid;
  logic [CNT_W-1:0] cnt;

  // pc_inc must be suppressed by a flush arriving in the same cycle, so the
  // registered first-cycle marker is gated combinationally.
  assign pc_inc = first_valid & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      drop            <= 1'b0;
      cnt             <= '0;
      first_valid     <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.instr_valid <= 1'b0;
      bus.instr_data  <= '0;
      bus.instr_pc    <= '0;
      bus.instr_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // pc_i is stale during a redirect; sample it one cycle later.
          if (!flush) begin
            bus.mem_addr <= pc_i;
            bus.mem_req  <= 1'b1;
            cnt          <= '0;
            state        <= REQ;
          end
        end

        REQ: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            drop        <= 1'b0;
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              bus.instr_data  <= bus.mem_rdata;
              bus.instr_pc    <= bus.mem_addr;
              bus.instr_fault <= 1'b0;
              bus.instr_valid <= 1'b1;
              first_valid     <= 1'b1;
              state           <= VALID;
            end
          end else if (cnt == CNT_MAX) begin
            bus.mem_req <= 1'b0;
            drop        <= 1'b0;
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              bus.instr_data  <= DATA_WIDTH'(NOP_INSTR);
              bus.instr_pc    <= bus.mem_addr;
              bus.instr_fault <= 1'b1;
              bus.instr_valid <= 1'b1;
              first_valid     <= 1'b1;
              state           <= VALID;
            end
          end else if (flush) begin
            // The request stays up until answered; its data is discarded.
            drop <= 1'b1;
          end
        end

        VALID: begin
          first_valid <= 1'b0;
          if (flush || bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            state           <= IDLE;
          end
        end

        default: begin
          state           <= IDLE;
          bus.mem_req     <= 1'b0;
          bus.instr_valid <= 1'b0;
          first_valid     <= 1'b0;
          drop            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: models the PC register and a
// latency-programmable instruction memory, and scoreboards delivered words.
module tb_fetch_unit;
  import risco5_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc = '0;
  logic [31:0] redir;
  logic        pc_inc;
  logic        flush;

  int          checks = 0;
  int          errors = 0;
  int          pinc_cnt = 0;
  int          lat;
  int          cur_lat = 0;
  int          w = 0;
  exp_t        sb[$];

  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .pc_i   (pc),
    .pc_inc (pc_inc),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 7);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PC register: load on redirect, else step on pc_inc.
  always @(posedge clk) begin
    if (flush) pc <= redir;
    else if (pc_inc) pc <= pc + 1;
  end

  // Memory: acks after cur_lat wait cycles, latency latched at request start.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (w == 0) cur_lat = lat;
        if (w == cur_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = word(bus.mem_addr);
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 32'hDEAD_BEEF;
        end
        w++;
      end else begin
        w           = 0;
        bus.mem_ack = 1'b0;
      end
    end
  end

  // Output monitor: count pc_inc pulses, pop scoreboard on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (pc_inc) pinc_cnt++;
    if (reset && bus.instr_valid && bus.instr_ready && !flush) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("sb_data",  64'(bus.instr_data),  64'(e.data));
        check("sb_pc",    64'(bus.instr_pc),    64'(e.pc));
        check("sb_fault", 64'(bus.instr_fault), 64'(e.fault));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int k);
    case (k)
      0:       return bus.mem_req;
      1:       return bus.instr_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int k, input int maxc, input string tag);
    int n = 0;
    while (!sel(k) && n < maxc) begin
      tick();
      n++;
    end
    check(tag, 64'(sel(k)), 64'd1);
  endtask

  initial begin
    int base;
    int n;
    logic saw;

    reset = 1'b0;
    flush = 1'b0;
    redir = '0;
    lat   = 1;
    bus.instr_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_mem_req", 64'(bus.mem_req),     64'd0);
    check("rst_addr",    64'(bus.mem_addr),    64'd0);
    check("rst_valid",   64'(bus.instr_valid), 64'd0);
    check("rst_data",    64'(bus.instr_data),  64'd0);
    check("rst_pc",      64'(bus.instr_pc),    64'd0);
    check("rst_fault",   64'(bus.instr_fault), 64'd0);
    check("rst_pc_inc",  64'(pc_inc),          64'd0);

    // Basic fetch from PC 0, one wait cycle
    reset = 1'b1;
    sb.push_back('{data: 32'h0050_0093, pc: 32'd0, fault: 1'b0});
    wait_for(0, 10, "s1_req");
    check("s1_addr", 64'(bus.mem_addr), 64'd0);
    wait_for(1, 10, "s1_valid");
    check("s1_pc_inc", 64'(pc_inc), 64'd1);
    tick();
    wait_for(0, 10, "s1_req2");
    check("s1_addr2", 64'(bus.mem_addr), 64'd1);
    check("s1_pinc_cnt", 64'(pinc_cnt), 64'd1);

    // Decode stalls 5 cycles with a buffered instruction
    bus.instr_ready = 1'b0;
    base = pinc_cnt;
    sb.push_back('{data: word(32'd1), pc: 32'd1, fault: 1'b0});
    wait_for(1, 10, "s2_valid");
    for (int i = 0; i < 5; i++) begin
      check("s2_valid_hold", 64'(bus.instr_valid), 64'd1);
      check("s2_data_hold",  64'(bus.instr_data),  64'(word(32'd1)));
      check("s2_pc_hold",    64'(bus.instr_pc),    64'd1);
      check("s2_no_req",     64'(bus.mem_req),     64'd0);
      tick();
    end
    check("s2_pinc_once", 64'(pinc_cnt - base), 64'd1);
    bus.instr_ready = 1'b1;
    tick();

    // Flush during REQ, ack arrives two cycles later and must be dropped
    lat  = 2;
    base = pinc_cnt;
    sb.push_back('{data: word(32'd47), pc: 32'd47, fault: 1'b0});
    wait_for(0, 10, "s3_req");
    flush = 1'b1;
    redir = 32'd47;
    tick();
    flush = 1'b0;
    lat   = 1;
    check("s3_req_held", 64'(bus.mem_req), 64'd1);
    saw = 1'b0;
    n   = 0;
    while (!(bus.mem_req && bus.mem_addr == 32'd47) && n < 12) begin
      if (bus.instr_valid) saw = 1'b1;
      tick();
      n++;
    end
    check("s3_addr",     64'(bus.mem_addr), 64'd47);
    check("s3_no_valid", 64'(saw),          64'd0);
    check("s3_no_pinc",  64'(pinc_cnt - base), 64'd0);
    wait_for(1, 10, "s3_valid");
    tick();

    // Flush in first VALID cycle with decode ready
    wait_for(1, 10, "s4_valid");
    base  = pinc_cnt;
    flush = 1'b1;
    redir = 32'd100;
    #1;
    check("s4_pc_inc_gated", 64'(pc_inc), 64'd0);
    tick();
    flush = 1'b0;
    check("s4_valid_drop", 64'(bus.instr_valid), 64'd0);
    sb.push_back('{data: word(32'd100), pc: 32'd100, fault: 1'b0});
    wait_for(0, 10, "s4_req");
    check("s4_addr",    64'(bus.mem_addr), 64'd100);
    check("s4_no_pinc", 64'(pinc_cnt - base), 64'd0);
    wait_for(1, 10, "s4_valid2");
    tick();

    // Memory never answers: timeout delivers a faulted NOP
    lat  = 99;
    base = pinc_cnt;
    sb.push_back('{data: NOP_INSTR, pc: 32'd101, fault: 1'b1});
    wait_for(0, 10, "s5_req");
    n = 0;
    while (bus.mem_req && n < 40) begin
      tick();
      n++;
    end
    check("s5_req_cycles", 64'(n),               64'd16);
    check("s5_valid",      64'(bus.instr_valid), 64'd1);
    check("s5_fault",      64'(bus.instr_fault), 64'd1);
    check("s5_nop",        64'(bus.instr_data),  64'(NOP_INSTR));
    tick();
    check("s5_pinc_once", 64'(pinc_cnt - base), 64'd1);

    // Reset while a request is outstanding
    wait_for(0, 10, "s6_req");
    tick();
    reset = 1'b0;
    tick();
    check("s6_req_low",   64'(bus.mem_req),     64'd0);
    check("s6_valid_low", 64'(bus.instr_valid), 64'd0);
    reset = 1'b1;
    lat   = 1;
    sb.push_back('{data: word(32'd102), pc: 32'd102, fault: 1'b0});
    wait_for(0, 10, "s6_req2");
    check("s6_addr", 64'(bus.mem_addr), 64'd102);
    wait_for(1, 10, "s6_valid");
    tick();
    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Samples the PC value, issues one instruction-memory read, and holds the returned word for decode behind a valid/ready handshake.
- Pulses pc_inc back to the PC so it advances by one word per delivered instruction.
- Handles redirect flushes (taken branch or jump, asserted together with the PC load) and memory timeouts.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address (word-addressed, PC steps by 1).
- DATA_WIDTH, 32, instruction width.
- TIMEOUT, 16, cycles mem_req may stay unacknowledged before a fetch fault.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- pc_i  in  ADDR_WIDTH  current PC register output.
- pc_inc  out  1  one-cycle pulse; PC adds 1 at the next edge.
- flush  in  1  redirect; asserted in the same cycle the PC is loaded.
- mem_req  out  1  read request; held until mem_ack or timeout.
- mem_addr  out  ADDR_WIDTH  word address; stable while mem_req = 1.
- mem_ack  in  1  mem_rdata valid this cycle; ignored unless mem_req = 1.
- mem_rdata  in  DATA_WIDTH  returned instruction.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts.
- instr_data  out  DATA_WIDTH  buffered instruction.
- instr_pc  out  ADDR_WIDTH  address of instr_data.
- instr_fault  out  1  instr_data is a substituted NOP after a timeout.

Behaviour:
- Reset (reset = 0 at edge): state IDLE, drop = 0, timeout counter = 0. Outputs reset to mem_req 0, mem_addr 0, instr_valid 0, instr_data 0, instr_pc 0, instr_fault 0, pc_inc 0. Reset mid-request abandons the request; mem_req is low the next cycle.
- State IDLE:
  - flush = 0: capture pc_i into mem_addr, go to REQ.
  - flush = 1: stay in IDLE without capturing, because pc_i is stale this cycle.
- State REQ:
  - mem_req = 1; counter increments each cycle.
  - mem_ack & ~drop & ~flush: latch instr_data = mem_rdata, instr_pc = mem_addr, instr_fault = 0; go to VALID.
  - mem_ack & (drop | flush): discard the data, clear drop, go to IDLE; no pc_inc.
  - flush & ~mem_ack: set drop and keep mem_req high. A request is never withdrawn early.
  - Counter reaches TIMEOUT-1 without ack:
    - drop = 0: deliver instr_data = 0x00000013 (NOP), instr_fault = 1, go to VALID.
    - drop = 1: go to IDLE.
    - mem_req falls in both cases.
- State VALID:
  - instr_valid = 1.
  - pc_inc = 1 only in the first VALID cycle, gated by ~flush.
  - instr_ready & ~flush: handshake completes, go to IDLE.
  - flush (regardless of instr_ready): no handshake, go to IDLE, instr_valid low next cycle.
- Ordering: the PC update from pc_inc lands at the edge ending the first VALID cycle, so IDLE always samples the incremented PC.
- Throughput: one instruction per 3 cycles minimum (IDLE, REQ with same-cycle ack, VALID accepted immediately).
- instr_data, instr_pc and instr_fault are stable while instr_valid = 1.
- mem_ack while not in REQ is ignored.

Decomposition:
- Package risco5_fetch_pkg holds:
  - fetch_state_t enum {IDLE, REQ, VALID}.
  - NOP_INSTR = 32'h00000013.
  - Default TIMEOUT constant.
- Single module with no sub-module. The timeout counter is inline; its width is $clog2(TIMEOUT).

Test Plan:
- Reset, pc_i = 0, memory acks after 1 wait cycle with 0x00500093, instr_ready = 1 → mem_addr = 0, instr_valid with instr_data 0x00500093 and instr_pc 0, one pc_inc pulse, next request at mem_addr = 1.
- instr_ready held 0 for 5 cycles with an instruction buffered → instr_valid, instr_data and instr_pc stay stable, pc_inc pulses exactly once, no new mem_req until acceptance.
- flush while in REQ, ack 2 cycles later, pc_i loaded to 47 → late data discarded, instr_valid stays 0, next mem_addr = 47, no pc_inc for the dropped fetch.
- flush in the first VALID cycle with instr_ready = 1 → no handshake, pc_inc suppressed, next fetch at the redirected pc_i.
- No ack for TIMEOUT = 16 cycles → mem_req drops after 16 cycles, instr_valid with instr_data 0x00000013 and instr_fault = 1, pc_inc pulses once.
- reset driven to 0 while in REQ → next cycle mem_req 0 and instr_valid 0; after release, fetch restarts from the current pc_i.
